// File: rtl/muldiv_sequencer_pkg.sv
// Shared types for the multi-cycle RV32M multiply/divide sequencer.
package muldiv_sequencer_pkg;

  // Encoding matches RV32M funct3, so bit 2 separates divide from multiply.
  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } muldiv_opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  function automatic logic op_a_signed(muldiv_opcode_e op);
    return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
  endfunction

  function automatic logic op_b_signed(muldiv_opcode_e op);
    return (op == MULH) || (op == DIV) || (op == REM);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// EX-stage handshake between the pipeline and the M-extension sequencer.
interface muldiv_sequencer_if
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             muldiv_enable_ip;
  muldiv_opcode_e   muldiv_operator_ip;
  logic [WIDTH-1:0] muldiv_operand_a_ip;
  logic [WIDTH-1:0] muldiv_operand_b_ip;
  logic             flush_ip;
  logic             muldiv_stall_op;
  logic [WIDTH-1:0] muldiv_result_op;
  logic             muldiv_valid_op;
  logic             muldiv_busy_op;

  modport master (
    output muldiv_enable_ip, muldiv_operator_ip, muldiv_operand_a_ip,
           muldiv_operand_b_ip, flush_ip,
    input  muldiv_stall_op, muldiv_result_op, muldiv_valid_op, muldiv_busy_op
  );

  modport slave (
    input  muldiv_enable_ip, muldiv_operator_ip, muldiv_operand_a_ip,
           muldiv_operand_b_ip, flush_ip,
    output muldiv_stall_op, muldiv_result_op, muldiv_valid_op, muldiv_busy_op
  );
endinterface

// File: rtl/muldiv_sequencer_iter_core.sv
// Radix-2 iteration datapath: shift-add multiply or restoring divide on
// unsigned magnitudes. hi/lo hold product high/low, or remainder/quotient.
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             step,
  input  logic             load,
  input  logic             is_div,
  input  logic [WIDTH-1:0] mag_a,
  input  logic [WIDTH-1:0] mag_b,
  output logic [WIDTH-1:0] raw_lo,
  output logic [WIDTH-1:0] raw_hi
);
  logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
  logic             is_div_q;
  logic [WIDTH:0]   add_sum, rem_sh, rem_diff;

  // One-step candidates for both algorithms.
  always_comb begin
    add_sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : {WIDTH{1'b0}})};
    rem_sh   = {hi_q, lo_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opnd_q};
  end

  // Multiplier (or dividend) sits in lo and is consumed one bit per step.
  always_ff @(posedge clock) begin
    if (!reset) begin
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
    end else if (load) begin
      hi_q     <= '0;
      lo_q     <= is_div ? mag_a : mag_b;
      opnd_q   <= is_div ? mag_b : mag_a;
      is_div_q <= is_div;
    end else if (step) begin
      if (is_div_q) begin
        if (!rem_diff[WIDTH]) begin
          hi_q <= rem_diff[WIDTH-1:0];
          lo_q <= {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_q <= rem_sh[WIDTH-1:0];
          lo_q <= {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        hi_q <= add_sum[WIDTH:1];
        lo_q <= {add_sum[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  assign raw_lo = lo_q;
  assign raw_hi = hi_q;
endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M controller: latches operands at EX, stalls the front end,
// iterates WIDTH cycles and emits a one-cycle result strobe.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset,
  muldiv_sequencer_if.slave  bus
);
  muldiv_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  muldiv_opcode_e   op_q;
  logic             sign_a_q, sign_b_q, spec_q;
  logic [WIDTH-1:0] spec_val_q;

  logic             start, sa, sb, spec_hit, b_zero, ovf;
  logic [WIDTH-1:0] a, b, mag_a, mag_b, spec_val, raw_lo, raw_hi;
  logic [WIDTH-1:0] quo, rem, res;
  logic [2*WIDTH-1:0] prod;
  muldiv_opcode_e   op;

  assign op    = bus.muldiv_operator_ip;
  assign a     = bus.muldiv_operand_a_ip;
  assign b     = bus.muldiv_operand_b_ip;
  assign start = (state_q == IDLE) && bus.muldiv_enable_ip && !bus.flush_ip;

  // Operand signs/magnitudes and the divide corner cases resolved at start.
  always_comb begin
    sa       = op_a_signed(op) & a[WIDTH-1];
    sb       = op_b_signed(op) & b[WIDTH-1];
    mag_a    = sa ? -a : a;
    mag_b    = sb ? -b : b;
    b_zero   = (b == '0);
    ovf      = ((op == DIV) || (op == REM)) &&
               (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    spec_hit = (op[2] && b_zero) || ovf;
    spec_val = '0;
    if (op[2] && b_zero) spec_val = op[1] ? a : '1;
    else if (ovf)        spec_val = op[1] ? '0 : a;
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = spec_hit ? DONE : BUSY;
      BUSY:    if (cnt_q == CNT_W'(WIDTH-1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush_ip) state_d = IDLE;
  end

  // State, iteration counter and the op context captured at start.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= MUL;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        cnt_q      <= '0;
        op_q       <= op;
        sign_a_q   <= sa;
        sign_b_q   <= sb;
        spec_q     <= spec_hit;
        spec_val_q <= spec_val;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clock  (clock),
    .reset  (reset),
    .step   (state_q == BUSY),
    .load   (start),
    .is_div (op[2]),
    .mag_a  (mag_a),
    .mag_b  (mag_b),
    .raw_lo (raw_lo),
    .raw_hi (raw_hi)
  );

  // Sign fix-up and half/quotient/remainder select for the DONE cycle.
  always_comb begin
    prod = {raw_hi, raw_lo};
    if (sign_a_q ^ sign_b_q) prod = -prod;
    quo = (sign_a_q ^ sign_b_q) ? -raw_lo : raw_lo;
    rem = sign_a_q ? -raw_hi : raw_hi;
    res = '0;
    case (op_q)
      MUL:                res = prod[WIDTH-1:0];
      MULH, MULHSU, MULHU: res = prod[2*WIDTH-1:WIDTH];
      DIV, DIVU:          res = quo;
      REM, REMU:          res = rem;
      default:            res = '0;
    endcase
    if (spec_q) res = spec_val_q;
  end

  assign bus.muldiv_valid_op  = (state_q == DONE) && !bus.flush_ip;
  assign bus.muldiv_result_op = bus.muldiv_valid_op ? res : '0;
  assign bus.muldiv_busy_op   = (state_q != IDLE);
  assign bus.muldiv_stall_op  = reset && bus.muldiv_enable_ip &&
                                (state_q != DONE) && !bus.flush_ip;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed M-ops, special cases,
// flush, mid-op reset, back-to-back issue and enable drop during BUSY.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  logic clock, reset;
  int   n_cmp = 0, n_bad = 0, n_valid = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        prev_valid = 1'b0;

  muldiv_sequencer_if #(.WIDTH(32)) bus ();
  muldiv_sequencer #(.WIDTH(32)) dut (.clock(clock), .reset(reset), .bus(bus));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever a result strobe is presented.
  initial begin
    forever begin
      @(negedge clock);
      if (prev_valid) begin
        chk("valid_single_cycle", {31'd0, bus.muldiv_valid_op}, 32'd0);
        chk("idle_after_done", {31'd0, bus.muldiv_busy_op}, 32'd0);
      end
      if (bus.muldiv_valid_op) begin
        n_valid++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_valid: got 0x%08h expected no strobe", bus.muldiv_result_op);
        end else begin
          chk(name_q.pop_front(), bus.muldiv_result_op, exp_q.pop_front());
        end
      end
      prev_valid = bus.muldiv_valid_op;
    end
  end

  // Called just after a posedge; returns just after the DONE posedge.
  task automatic run_op(input muldiv_opcode_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_stall, input bit keep,
                        input string nm);
    int n;
    bus.muldiv_operator_ip  = op;
    bus.muldiv_operand_a_ip = a;
    bus.muldiv_operand_b_ip = b;
    bus.muldiv_enable_ip    = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (!bus.muldiv_stall_op) break;
      n++;
    end
    chk({"stall_", nm}, n, exp_stall);
    @(posedge clock); #1;
    if (!keep) bus.muldiv_enable_ip = 1'b0;
  endtask

  initial begin
    int base;
    reset = 1'b0;
    bus.flush_ip = 1'b0;
    bus.muldiv_enable_ip = 1'b1;
    bus.muldiv_operator_ip = DIV;
    bus.muldiv_operand_a_ip = 32'd9;
    bus.muldiv_operand_b_ip = 32'd3;
    @(negedge clock);
    chk("rst_stall", {31'd0, bus.muldiv_stall_op}, 32'd0);
    @(negedge clock);
    chk("rst_valid", {31'd0, bus.muldiv_valid_op}, 32'd0);
    chk("rst_busy", {31'd0, bus.muldiv_busy_op}, 32'd0);
    chk("rst_result", bus.muldiv_result_op, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    bus.muldiv_enable_ip = 1'b0;
    @(posedge clock); #1;

    run_op(MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 0, "mul_7_m3");
    run_op(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0, "mulhu_ff");
    run_op(MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, 0, "mulh_ff");
    run_op(MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 0, "mulhsu_ff");
    run_op(DIV,    32'hFFFFFFEC, 32'd6,        32'hFFFFFFFD, 33, 0, "div_m20_6");
    run_op(REM,    32'hFFFFFFEC, 32'd6,        32'hFFFFFFFE, 33, 0, "rem_m20_6");
    run_op(DIVU,   32'd100,      32'd7,        32'd14,       33, 0, "divu_100_7");
    run_op(DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1,  0, "div_by0");
    run_op(REMU,   32'd5,        32'd0,        32'd5,        1,  0, "remu_by0");
    run_op(DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  0, "div_ovf");
    run_op(REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  0, "rem_ovf");

    // Flush at iteration 10 of a DIVU.
    bus.muldiv_operator_ip  = DIVU;
    bus.muldiv_operand_a_ip = 32'd1000;
    bus.muldiv_operand_b_ip = 32'd3;
    bus.muldiv_enable_ip    = 1'b1;
    @(posedge clock);
    repeat (10) @(posedge clock);
    #1 bus.flush_ip = 1'b1;
    @(negedge clock);
    chk("flush_stall", {31'd0, bus.muldiv_stall_op}, 32'd0);
    chk("flush_valid", {31'd0, bus.muldiv_valid_op}, 32'd0);
    @(posedge clock); #1;
    bus.flush_ip = 1'b0;
    bus.muldiv_enable_ip = 1'b0;
    @(negedge clock);
    chk("flush_busy", {31'd0, bus.muldiv_busy_op}, 32'd0);
    @(posedge clock); #1;
    run_op(MUL, 32'd3, 32'd4, 32'd12, 33, 0, "mul_after_flush");

    // One-cycle reset in the middle of BUSY.
    bus.muldiv_operator_ip  = MUL;
    bus.muldiv_operand_a_ip = 32'd9;
    bus.muldiv_operand_b_ip = 32'd9;
    bus.muldiv_enable_ip    = 1'b1;
    repeat (5) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("midrst_stall", {31'd0, bus.muldiv_stall_op}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    bus.muldiv_enable_ip = 1'b0;
    @(negedge clock);
    chk("midrst_busy", {31'd0, bus.muldiv_busy_op}, 32'd0);
    chk("midrst_valid", {31'd0, bus.muldiv_valid_op}, 32'd0);
    chk("midrst_result", bus.muldiv_result_op, 32'd0);
    @(posedge clock); #1;

    // Back-to-back issue with no gap after DONE.
    run_op(MUL, 32'd2, 32'd3, 32'd6,  33, 1, "b2b_first");
    run_op(MUL, 32'd5, 32'd5, 32'd25, 33, 0, "b2b_second");

    // Enable dropped during BUSY: the op still completes.
    bus.muldiv_operator_ip  = DIVU;
    bus.muldiv_operand_a_ip = 32'd100;
    bus.muldiv_operand_b_ip = 32'd7;
    bus.muldiv_enable_ip    = 1'b1;
    exp_q.push_back(32'd14);
    name_q.push_back("en_drop_result");
    base = n_valid;
    repeat (3) @(posedge clock);
    #1 bus.muldiv_enable_ip = 1'b0;
    bus.muldiv_operand_a_ip = 32'd555;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (n_valid != base) break;
    end
    chk("en_drop_valid_seen", n_valid - base, 32'd1);

    repeat (3) @(posedge clock);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle controller for RV32M multiply/divide operations issued to the Execute stage alongside the single-cycle ALU. It latches forwarded operands when an M-op reaches EX, stalls the front of the pipeline, and runs a radix-2 iterative shift-add or restoring-divide engine. It then presents a one-cycle valid result that the EX-MEM buffer captures in place of the ALU result. It also handles pipeline flush and the RISC-V divide special cases.

Parameters:
WIDTH, 32, operand/result width; the iteration count equals WIDTH
CNT_W, $clog2(WIDTH), iteration counter width (derived, not overridden)

Ports:
clock  input  1  core clock, rising-edge
reset  input  1  synchronous, active-low reset (sampled on posedge clock; 0 = reset)
muldiv_enable_ip  input  1  M-op present in EX this cycle
muldiv_operator_ip  input  3  muldiv_opcode_e: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
muldiv_operand_a_ip  input  WIDTH  rs1 after forwarding mux
muldiv_operand_b_ip  input  WIDTH  rs2 after forwarding mux
flush_ip  input  1  cancel in-flight op (branch/jump flush)
muldiv_stall_op  output  1  holds IF/ID/EX registers; combinational
muldiv_result_op  output  WIDTH  result; meaningful only while valid
muldiv_valid_op  output  1  one-cycle result strobe
muldiv_busy_op  output  1  state is not IDLE

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (reset==0 at posedge): state=IDLE, counter=0, result=0, valid=0, busy=0. Stall is 0 while reset is asserted. Reset mid-operation discards the op.
- IDLE -> start when enable=1 and flush=0:
  - Latch operator and operands.
  - Compute sign flags: a signed for MULH/MULHSU/DIV/REM; b signed for MULH/DIV/REM.
  - Take magnitudes of both operands.
- Special cases at start go straight to DONE, with 1 cycle of stall total:
  - DIV/DIVU with b==0: result = all ones.
  - REM/REMU with b==0: result = a.
  - DIV with a==0x80000000 and b==0xFFFFFFFF: result = 0x80000000.
  - REM with the same operands: result = 0.
- Otherwise IDLE -> BUSY with counter=0. BUSY runs exactly WIDTH cycles (counter 0..WIDTH-1), one iteration per cycle:
  - Multiply: 2*WIDTH-bit accumulator, shift-add.
  - Divide: restoring, quotient and remainder registers.
  - At counter==WIDTH-1, move to DONE.
- DONE, the cycle after the last iteration:
  - Apply sign fix-ups. Product is negated if sign_a^sign_b. Quotient is negated if sign_a^sign_b. Remainder is negated if sign_a.
  - Select the low half for MUL and the high half for MULH/MULHSU/MULHU.
  - valid=1 and result driven; stall=0 so the pipeline advances; next state IDLE.
- Stall rule: stall = enable & (state != DONE) & ~flush. Total stall for a normal op is WIDTH+1 cycles; the valid strobe arrives WIDTH+2 cycles after enable first rises.
- Back-to-back M-ops: an op entering EX in the cycle after DONE starts normally from IDLE. There is no bubble beyond the IDLE start cycle.
- Flush has priority over everything except reset. In any state it forces IDLE, valid=0, and discards the latched op.
- enable dropping during BUSY (illegal unless flushed): the sequencer completes and asserts valid; assertion-checked in the bench.
- Operands are sampled only at start, so later changes on the forwarding path are ignored.
- valid is never high for two consecutive cycles.

Decomposition:
- CORE_PKG additions: muldiv_opcode_e (3-bit enum) and muldiv_state_e {IDLE, BUSY, DONE}.
- Sub-module muldiv_iter_core holds the accumulator, quotient and remainder registers and the one-step shift-add/subtract datapath. It has ports: step, load, is_div, mag_a, mag_b, raw_lo, raw_hi.
- muldiv_sequencer owns the FSM, counter, sign handling, special-case detection and stall/valid generation.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD) -> stall high 33 cycles; valid pulse with result 0xFFFFFFEB (-21); state IDLE afterwards.
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> result 0xFFFFFFFE. MULH with the same operands -> 0x00000000. MULHSU a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=-20, b=6 -> result 0xFFFFFFFD (-3). REM with the same operands -> 0xFFFFFFFE (-2). DIVU a=100, b=7 -> 14.
- DIV a=5, b=0 -> 0xFFFFFFFF after 1 stall cycle. REMU a=5, b=0 -> 5. DIV a=0x80000000, b=-1 -> 0x80000000. REM with the same operands -> 0.
- Start DIVU, assert flush at iteration 10 -> no valid, stall drops that cycle, busy=0 next cycle. A new MUL 3*4 issued immediately after -> result 12.
- Drive reset=0 mid-BUSY for one posedge -> all outputs 0 and state IDLE. Back-to-back MUL 2*3 then MUL 5*5 -> two single-cycle valid pulses, results 6 then 25, each preceded by 33 stall cycles.
